// File: rtl/multi_palette_lut_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multi_palette_pkg
// Description : Shared types and constants for the multi-palette colour LUT:
//               packed 12-bit RGB type, the power-on default palette and the
//               commit state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package multi_palette_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    localparam int DEF_ENTRIES = 16;

    // Entry i of every palette resets to DEFAULT_PALETTE[i mod 16].
    localparam logic [11:0] DEFAULT_PALETTE [DEF_ENTRIES] = '{
        12'hFFF, 12'h333, 12'h889, 12'hA00, 12'h135, 12'hB76, 12'h411, 12'hEDD,
        12'h632, 12'h667, 12'h211, 12'hDAA, 12'h700, 12'h954, 12'hABB, 12'h113
    };

    // Commit handshake states.
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PENDING = 1'b1;

    function automatic rgb12_t default_rgb(input int idx);
        return rgb12_t'(DEFAULT_PALETTE[idx % DEF_ENTRIES]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/multi_palette_lut_palette_bank.sv
`default_nettype none
// ============================================================================
// Module      : palette_bank
// Description : NUM_PAL x 2**INDEX_W flop array of RGB entries.
//               One synchronous write port, one asynchronous read port and a
//               whole-bank load port. Reset loads the default palette.
// Ports       : Clk, reset_n          clock / async active-low reset
//               wr_en_i/pal/idx/rgb   single-entry write (pal >= NUM_PAL dropped)
//               load_en_i/load_data_i whole-bank load (wins over a write)
//               rd_pal_i/rd_idx_i     async read address (pal >= NUM_PAL -> 0)
//               rd_rgb_o              read data
//               bank_data_o           full bank contents, flattened
// Revision    : 1.0 - initial release
// ============================================================================
module palette_bank
    import multi_palette_pkg::*;
#(
    parameter int INDEX_W = 4,
    parameter int NUM_PAL = 8,
    parameter int PAL_W   = 3,
    parameter int COLOR_W = 4
) (
    input  logic                                             Clk,
    input  logic                                             reset_n,
    input  logic                                             wr_en_i,
    input  logic [PAL_W-1:0]                                 wr_pal_i,
    input  logic [INDEX_W-1:0]                               wr_idx_i,
    input  logic [3*COLOR_W-1:0]                             wr_rgb_i,
    input  logic                                             load_en_i,
    input  logic [NUM_PAL*(2**INDEX_W)*3*COLOR_W-1:0]        load_data_i,
    input  logic [PAL_W-1:0]                                 rd_pal_i,
    input  logic [INDEX_W-1:0]                               rd_idx_i,
    output logic [3*COLOR_W-1:0]                             rd_rgb_o,
    output logic [NUM_PAL*(2**INDEX_W)*3*COLOR_W-1:0]        bank_data_o
);

    localparam int DEPTH   = 2**INDEX_W;
    localparam int ENTRIES = NUM_PAL * DEPTH;
    localparam int RGB_W   = 3 * COLOR_W;
    localparam logic [PAL_W:0] NUM_PAL_L = (PAL_W+1)'(NUM_PAL);

    // Entry address is {pal, idx}, i.e. pal*DEPTH + idx.
    logic [ENTRIES-1:0][RGB_W-1:0] mem_q;

    logic                  w_wr_ok;
    logic [PAL_W-1:0]      w_rd_pal;

    // Stretch/trim a 4-bit default channel to COLOR_W by repeating its bits
    // MSB-first, so full-scale stays full-scale at any width.
    function automatic logic [COLOR_W-1:0] widen(input logic [3:0] c);
        logic [COLOR_W-1:0] w;
        w = '0;
        for (int i = 0; i < COLOR_W; i++) begin
            w[COLOR_W-1-i] = c[3-(i%4)];
        end
        return w;
    endfunction

    function automatic logic [RGB_W-1:0] reset_entry(input int e);
        rgb12_t d;
        d = default_rgb(e % DEPTH);
        return {widen(d.r), widen(d.g), widen(d.b)};
    endfunction

    assign w_wr_ok  = wr_en_i && ({1'b0, wr_pal_i} < NUM_PAL_L);
    assign w_rd_pal = ({1'b0, rd_pal_i} < NUM_PAL_L) ? rd_pal_i : '0;

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int e = 0; e < ENTRIES; e++) begin
                mem_q[e] <= reset_entry(e);
            end
        end else if (load_en_i) begin
            mem_q <= load_data_i;
        end else if (w_wr_ok) begin
            mem_q[{wr_pal_i, wr_idx_i}] <= wr_rgb_i;
        end
    end

    assign rd_rgb_o    = mem_q[{w_rd_pal, rd_idx_i}];
    assign bank_data_o = mem_q;

endmodule
`default_nettype wire

// File: rtl/multi_palette_lut.sv
`default_nettype none
// ============================================================================
// Module      : multi_palette_lut
// Description : Double-buffered multi-palette colour lookup, 2-cycle latency.
//               Writes go to a shadow bank; a requested commit copies the
//               whole shadow bank into the active bank on frame start.
// Ports       : Clk, reset_n                  clock / async active-low reset
//               pix_valid_i/pal/idx, flash_i  lookup request
//               frame_start_i                 frame start pulse
//               wr_en_i/pal/idx/rgb           shadow-bank write
//               commit_req_i                  request a commit
//               red_o/green_o/blue_o          looked-up colour
//               transparent_o, pix_valid_o    lookup status
//               commit_pending_o/done_o       commit status
// Revision    : 1.0 - initial release
// ============================================================================
module multi_palette_lut
    import multi_palette_pkg::*;
#(
    parameter int INDEX_W    = 4,
    parameter int NUM_PAL    = 8,
    parameter int PAL_W      = 3,
    parameter int COLOR_W    = 4,
    parameter int TRANSP_IDX = 0
) (
    input  logic                   Clk,
    input  logic                   reset_n,
    input  logic                   pix_valid_i,
    input  logic [PAL_W-1:0]       pix_pal_i,
    input  logic [INDEX_W-1:0]     pix_idx_i,
    input  logic                   flash_i,
    input  logic                   frame_start_i,
    input  logic                   wr_en_i,
    input  logic [PAL_W-1:0]       wr_pal_i,
    input  logic [INDEX_W-1:0]     wr_idx_i,
    input  logic [3*COLOR_W-1:0]   wr_rgb_i,
    input  logic                   commit_req_i,
    output logic [COLOR_W-1:0]     red_o,
    output logic [COLOR_W-1:0]     green_o,
    output logic [COLOR_W-1:0]     blue_o,
    output logic                   transparent_o,
    output logic                   pix_valid_o,
    output logic                   commit_pending_o,
    output logic                   commit_done_o
);

    localparam int RGB_W  = 3 * COLOR_W;
    localparam int BANK_W = NUM_PAL * (2**INDEX_W) * RGB_W;

    // Stage 1
    logic                 s1_valid_q;
    logic [PAL_W-1:0]     s1_pal_q;
    logic [INDEX_W-1:0]   s1_idx_q;
    logic                 s1_flash_q;

    // Stage 2 / outputs
    logic [RGB_W-1:0]     rgb_q;
    logic                 transp_q;
    logic                 valid_q;

    // Commit control
    logic [0:0]           state_q;
    logic [0:0]           state_d;
    logic                 done_q;
    logic                 w_commit;

    logic [BANK_W-1:0]    w_shadow_data;
    logic [BANK_W-1:0]    w_active_data;
    logic [RGB_W-1:0]     w_shadow_rd;
    logic [RGB_W-1:0]     w_active_rd;
    logic                 w_transp;
    logic [RGB_W-1:0]     w_rgb_s2;

    // A request in the same cycle as frame start commits without waiting
    // for the pending flag to register.
    assign w_commit = frame_start_i && ((state_q == ST_PENDING) || commit_req_i);

    palette_bank #(
        .INDEX_W (INDEX_W),
        .NUM_PAL (NUM_PAL),
        .PAL_W   (PAL_W),
        .COLOR_W (COLOR_W)
    ) u_shadow (
        .Clk         (Clk),
        .reset_n     (reset_n),
        .wr_en_i     (wr_en_i),
        .wr_pal_i    (wr_pal_i),
        .wr_idx_i    (wr_idx_i),
        .wr_rgb_i    (wr_rgb_i),
        .load_en_i   (1'b0),
        .load_data_i ('0),
        .rd_pal_i    ('0),
        .rd_idx_i    ('0),
        .rd_rgb_o    (w_shadow_rd),
        .bank_data_o (w_shadow_data)
    );

    // Active bank is only ever bulk-loaded from the pre-edge shadow contents,
    // so a write landing on the commit edge stays in shadow only.
    palette_bank #(
        .INDEX_W (INDEX_W),
        .NUM_PAL (NUM_PAL),
        .PAL_W   (PAL_W),
        .COLOR_W (COLOR_W)
    ) u_active (
        .Clk         (Clk),
        .reset_n     (reset_n),
        .wr_en_i     (1'b0),
        .wr_pal_i    ('0),
        .wr_idx_i    ('0),
        .wr_rgb_i    ('0),
        .load_en_i   (w_commit),
        .load_data_i (w_shadow_data),
        .rd_pal_i    (s1_pal_q),
        .rd_idx_i    (s1_idx_q),
        .rd_rgb_o    (w_active_rd),
        .bank_data_o (w_active_data)
    );

    assign w_transp = (s1_idx_q == INDEX_W'(TRANSP_IDX));
    assign w_rgb_s2 = (s1_flash_q && !w_transp) ? {RGB_W{1'b1}} : w_active_rd;

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_pal_q   <= '0;
            s1_idx_q   <= '0;
            s1_flash_q <= 1'b0;
            valid_q    <= 1'b0;
            rgb_q      <= '0;
            transp_q   <= 1'b0;
        end else begin
            s1_valid_q <= pix_valid_i;
            s1_pal_q   <= pix_pal_i;
            s1_idx_q   <= pix_idx_i;
            s1_flash_q <= flash_i;
            valid_q    <= s1_valid_q;
            // Data outputs hold their last value between valid pixels.
            if (s1_valid_q) begin
                rgb_q    <= w_rgb_s2;
                transp_q <= w_transp;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (w_commit) begin
            state_d = ST_IDLE;
        end else if (commit_req_i) begin
            state_d = ST_PENDING;
        end
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= w_commit;
        end
    end

    assign red_o            = rgb_q[2*COLOR_W +: COLOR_W];
    assign green_o          = rgb_q[COLOR_W   +: COLOR_W];
    assign blue_o           = rgb_q[0         +: COLOR_W];
    assign transparent_o    = transp_q;
    assign pix_valid_o      = valid_q;
    assign commit_pending_o = (state_q == ST_PENDING);
    assign commit_done_o    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_palette_lut.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_palette_lut
// Description : Self-checking bench for multi_palette_lut. A frame-level
//               model (shadow/active tables plus a pending flag) predicts the
//               outputs every cycle; directed literal checks pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_palette_lut;

    localparam int INDEX_W    = 4;
    localparam int NUM_PAL    = 8;
    localparam int PAL_W      = 3;
    localparam int COLOR_W    = 4;
    localparam int TRANSP_IDX = 0;

    logic                 Clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 pix_valid_i = 1'b0;
    logic [PAL_W-1:0]     pix_pal_i = '0;
    logic [INDEX_W-1:0]   pix_idx_i = '0;
    logic                 flash_i = 1'b0;
    logic                 frame_start_i = 1'b0;
    logic                 wr_en_i = 1'b0;
    logic [PAL_W-1:0]     wr_pal_i = '0;
    logic [INDEX_W-1:0]   wr_idx_i = '0;
    logic [11:0]          wr_rgb_i = '0;
    logic                 commit_req_i = 1'b0;

    logic [3:0] red_o, green_o, blue_o;
    logic       transparent_o, pix_valid_o, commit_pending_o, commit_done_o;
    logic [3:0] red6, green6, blue6;
    logic       transp6, valid6, pending6, done6;

    always #5 Clk = ~Clk;

    multi_palette_lut dut (
        .Clk(Clk), .reset_n(reset_n),
        .pix_valid_i(pix_valid_i), .pix_pal_i(pix_pal_i), .pix_idx_i(pix_idx_i),
        .flash_i(flash_i), .frame_start_i(frame_start_i),
        .wr_en_i(wr_en_i), .wr_pal_i(wr_pal_i), .wr_idx_i(wr_idx_i), .wr_rgb_i(wr_rgb_i),
        .commit_req_i(commit_req_i),
        .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
        .transparent_o(transparent_o), .pix_valid_o(pix_valid_o),
        .commit_pending_o(commit_pending_o), .commit_done_o(commit_done_o)
    );

    // Same stimulus, six palettes: palette 7 is out of range here.
    multi_palette_lut #(.NUM_PAL(6)) dut6 (
        .Clk(Clk), .reset_n(reset_n),
        .pix_valid_i(pix_valid_i), .pix_pal_i(pix_pal_i), .pix_idx_i(pix_idx_i),
        .flash_i(flash_i), .frame_start_i(frame_start_i),
        .wr_en_i(wr_en_i), .wr_pal_i(wr_pal_i), .wr_idx_i(wr_idx_i), .wr_rgb_i(wr_rgb_i),
        .commit_req_i(commit_req_i),
        .red_o(red6), .green_o(green6), .blue_o(blue6),
        .transparent_o(transp6), .pix_valid_o(valid6),
        .commit_pending_o(pending6), .commit_done_o(done6)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [11:0] DEF [16] = '{
        12'hFFF, 12'h333, 12'h889, 12'hA00, 12'h135, 12'hB76, 12'h411, 12'hEDD,
        12'h632, 12'h667, 12'h211, 12'hDAA, 12'h700, 12'h954, 12'hABB, 12'h113
    };
    logic [11:0] m_shadow [NUM_PAL][16];
    logic [11:0] m_active [NUM_PAL][16];
    bit          m_pending, m_done, m_valid, m_tr;
    logic [11:0] m_rgb;
    bit          q_v, q_fl;
    int          q_pal, q_idx;

    always @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < NUM_PAL; p++)
                for (int i = 0; i < 16; i++) begin
                    m_shadow[p][i] = DEF[i];
                    m_active[p][i] = DEF[i];
                end
            m_pending = 0; m_done = 0; m_valid = 0; m_tr = 0; m_rgb = '0;
            q_v = 0; q_fl = 0; q_pal = 0; q_idx = 0;
        end else begin : model_step
            bit fire;
            int p;
            // Request accepted one edge ago is resolved against the table
            // as it stands before this edge.
            m_valid = q_v;
            if (q_v) begin
                p     = (q_pal < NUM_PAL) ? q_pal : 0;
                m_tr  = (q_idx == TRANSP_IDX);
                m_rgb = (q_fl && !m_tr) ? 12'hFFF : m_active[p][q_idx];
            end
            q_v = pix_valid_i; q_pal = int'(pix_pal_i); q_idx = int'(pix_idx_i); q_fl = flash_i;
            fire   = frame_start_i && (m_pending || commit_req_i);
            m_done = fire;
            if (fire) begin
                m_active  = m_shadow;
                m_pending = 0;
            end else if (commit_req_i) begin
                m_pending = 1;
            end
            if (wr_en_i && (int'(wr_pal_i) < NUM_PAL))
                m_shadow[wr_pal_i][wr_idx_i] = wr_rgb_i;
        end
    end

    bit chk_en = 0;

    always @(negedge Clk) begin
        if (chk_en) begin
            chk("pix_valid", pix_valid_o, m_valid);
            chk("pending", commit_pending_o, m_pending);
            chk("done", commit_done_o, m_done);
            if (m_valid) begin
                chk("rgb", {red_o, green_o, blue_o}, m_rgb);
                chk("transparent", transparent_o, m_tr);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic lookup_chk(input int pal, input int idx, input bit fl,
                              input logic [11:0] exp_rgb, input bit exp_tr, input string nm);
        @(negedge Clk);
        pix_valid_i = 1; pix_pal_i = PAL_W'(pal); pix_idx_i = INDEX_W'(idx); flash_i = fl;
        @(negedge Clk);
        pix_valid_i = 0; flash_i = 0;
        @(negedge Clk);
        chk({nm, "_valid"}, pix_valid_o, 1);
        chk({nm, "_rgb"}, {red_o, green_o, blue_o}, exp_rgb);
        chk({nm, "_transp"}, transparent_o, exp_tr);
    endtask

    task automatic write_shadow(input int pal, input int idx, input logic [11:0] rgb);
        @(negedge Clk);
        wr_en_i = 1; wr_pal_i = PAL_W'(pal); wr_idx_i = INDEX_W'(idx); wr_rgb_i = rgb;
        @(negedge Clk);
        wr_en_i = 0;
    endtask

    task automatic commit_now(input string nm);
        @(negedge Clk);
        commit_req_i = 1; frame_start_i = 1;
        @(negedge Clk);
        commit_req_i = 0; frame_start_i = 0;
        chk({nm, "_done"}, commit_done_o, 1);
        chk({nm, "_pending"}, commit_pending_o, 0);
    endtask

    logic [11:0] b2b_exp [3] = '{12'h333, 12'h889, 12'hA00};

    initial begin
        // Reset state
        repeat (3) @(negedge Clk);
        chk("rst_valid", pix_valid_o, 0);
        chk("rst_rgb", {red_o, green_o, blue_o}, 0);
        chk("rst_transp", transparent_o, 0);
        chk("rst_pending", commit_pending_o, 0);
        chk("rst_done", commit_done_o, 0);
        reset_n = 1;
        chk_en  = 1;

        // Basic lookups
        lookup_chk(0, 3, 0, 12'hA00, 0, "p0i3");
        lookup_chk(0, 0, 0, 12'hFFF, 1, "p0i0");
        lookup_chk(0, 7, 0, 12'hEDD, 0, "p0i7");

        // Back-to-back, one result per cycle, latency 2
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            if (i >= 2) chk("b2b_rgb", {red_o, green_o, blue_o}, b2b_exp[i-2]);
            if (i < 3) begin
                pix_valid_i = 1; pix_pal_i = '0; pix_idx_i = INDEX_W'(i + 1);
            end else begin
                pix_valid_i = 0;
            end
        end

        // Shadow write is invisible until committed
        write_shadow(2, 5, 12'h0F0);
        lookup_chk(2, 5, 0, 12'hB76, 0, "shadow_hidden");
        commit_now("commit1");
        lookup_chk(2, 5, 0, 12'h0F0, 0, "after_commit1");

        // Frame start without a pending request does nothing
        write_shadow(3, 1, 12'h123);
        @(negedge Clk); frame_start_i = 1;
        @(negedge Clk); frame_start_i = 0;
        chk("fs_only_done", commit_done_o, 0);
        lookup_chk(3, 1, 0, 12'h333, 0, "fs_only");

        // Sticky pending, repeated requests absorbed; write on the commit edge excluded
        @(negedge Clk); commit_req_i = 1;
        @(negedge Clk); commit_req_i = 1;
        @(negedge Clk); commit_req_i = 0;
        chk("pend_sticky", commit_pending_o, 1);
        wr_en_i = 1; wr_pal_i = 3'd2; wr_idx_i = 4'd5; wr_rgb_i = 12'h00F; frame_start_i = 1;
        @(negedge Clk);
        wr_en_i = 0; frame_start_i = 0;
        chk("edge_wr_done", commit_done_o, 1);
        lookup_chk(2, 5, 0, 12'h0F0, 0, "edge_wr_old");

        // Lookup in flight across the second commit: old then new
        @(negedge Clk);
        pix_valid_i = 1; pix_pal_i = 3'd2; pix_idx_i = 4'd5;
        @(negedge Clk);
        commit_req_i = 1; frame_start_i = 1;
        @(negedge Clk);
        pix_valid_i = 0; commit_req_i = 0; frame_start_i = 0;
        chk("inflight_old", {red_o, green_o, blue_o}, 12'h0F0);
        chk("commit2_done", commit_done_o, 1);
        @(negedge Clk);
        chk("inflight_new", {red_o, green_o, blue_o}, 12'h00F);

        // Flash
        lookup_chk(0, 4, 1, 12'hFFF, 0, "flash_i4");
        lookup_chk(0, 0, 1, 12'hFFF, 1, "flash_i0");
        lookup_chk(0, 9, 1, 12'hFFF, 0, "flash_i9");

        // Out-of-range palette on the six-palette instance
        write_shadow(7, 3, 12'h0F0);
        commit_now("commit3");
        @(negedge Clk);
        pix_valid_i = 1; pix_pal_i = 3'd7; pix_idx_i = 4'd3;
        @(negedge Clk);
        pix_valid_i = 0;
        @(negedge Clk);
        chk("np6_valid", valid6, 1);
        chk("np6_pal7_rgb", {red6, green6, blue6}, 12'hA00);
        chk("np8_pal7_rgb", {red_o, green_o, blue_o}, 12'h0F0);

        // Reset while a commit is pending and a pixel is in flight
        @(negedge Clk);
        commit_req_i = 1; pix_valid_i = 1; pix_pal_i = '0; pix_idx_i = 4'd3;
        @(negedge Clk);
        commit_req_i = 0;
        @(negedge Clk);
        pix_valid_i = 0;
        chk("pre_rst_pending", commit_pending_o, 1);
        chk("pre_rst_valid", pix_valid_o, 1);
        #2;
        chk_en  = 0;
        reset_n = 0;
        #1;
        chk("mid_rst_pending", commit_pending_o, 0);
        chk("mid_rst_valid", pix_valid_o, 0);
        chk("mid_rst_rgb", {red_o, green_o, blue_o}, 0);
        @(negedge Clk);
        reset_n = 1;
        chk_en  = 1;
        lookup_chk(2, 5, 0, 12'hB76, 0, "post_rst_default");
        lookup_chk(7, 3, 0, 12'hA00, 0, "post_rst_pal7");

        repeat (2) @(negedge Clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
